// File: rtl/picobus_pkg.sv
// Shared bus definitions for the picobus-style memory port: write-strobe
// encodings, word size, and the state encoding of the mem_dma_copy engine.
package picobus_pkg;

  localparam logic [3:0]  WSTRB_FULL = 4'b1111;
  localparam logic [3:0]  WSTRB_NONE = 4'b0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_FIN    = 3'd5
  } dma_state_t;

  // Force a byte address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_dma_copy_if.sv
// Memory request/response bundle for picobus-style masters and responders.
//
// Handshake: the master raises mem_valid and holds mem_addr, mem_wdata and
// mem_wstrb stable until it samples mem_ready high on a rising edge; that
// edge completes the transfer. mem_wstrb == 0 marks a read, whose data is
// taken from mem_rdata on the same edge. mem_ready has no meaning while
// mem_valid is low.
interface mem_dma_copy_if;
  import picobus_pkg::*;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_dma_timeout.sv
// Wait counter for an outstanding bus request. Held at zero while clear is
// high; otherwise counts one per cycle and flags expire on the TIMEOUT-th
// cycle of waiting, so a request that never sees mem_ready stays valid for
// exactly TIMEOUT cycles.
module mem_dma_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, saturate once the limit is reached.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      expire = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_dma_copy.sv
// Word-granular memory copy engine on a picobus-style request port.
// Each word is read from src and written to dst (two requests per word);
// every accepted request is followed by one idle gap cycle. A request left
// unanswered for TIMEOUT cycles is abandoned, the sticky error flag is set
// and the transfer finishes early.
//
// Optional feature: define MEM_DMA_FILL_EN to honour fill_mode, which writes
// the latched fill_data to every destination word without any reads. When
// the macro is absent fill_mode/fill_data are accepted but ignored.
module mem_dma_copy
  import picobus_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             fill_mode,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_valid,
  output logic             mem_instr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output dma_state_t       dbg_state
);

  dma_state_t       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;
  logic             fill_q, fill_d;
  logic             error_q, error_d;

  logic             tmo_clear;
  logic             tmo_expire;

`ifndef MEM_DMA_FILL_EN
  // Fill inputs have no function in the copy-only build.
  logic unused_fill;
  assign unused_fill = ^{fill_mode, fill_data};
`endif

  mem_dma_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (tmo_clear),
    .expire (tmo_expire)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign error     = error_q;
  assign mem_instr = 1'b0;
  assign dbg_state = state_q;

  // Next-state, datapath updates and bus request decode.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    fill_d    = fill_q;
    error_d   = error_q;
    mem_valid = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = WSTRB_NONE;
    tmo_clear = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = word_align(src_addr);
          dst_d   = word_align(dst_addr);
          rem_d   = len;
          error_d = 1'b0;
`ifdef MEM_DMA_FILL_EN
          fill_d  = fill_mode;
          data_d  = fill_data;
`else
          fill_d  = 1'b0;
`endif
          if (len == '0)  state_d = ST_FIN;
          else if (fill_d) state_d = ST_WR_REQ;
          else             state_d = ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = src_q;
        mem_wstrb = WSTRB_NONE;
        tmo_clear = 1'b0;
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = ST_RD_GAP;
        end else if (tmo_expire) begin
          error_d = 1'b1;
          state_d = ST_FIN;
        end
      end

      ST_RD_GAP: begin
        state_d = ST_WR_REQ;
      end

      ST_WR_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = data_q;
        mem_wstrb = WSTRB_FULL;
        tmo_clear = 1'b0;
        if (mem_ready) begin
          src_d   = src_q + WORD_BYTES;
          dst_d   = dst_q + WORD_BYTES;
          rem_d   = rem_q - LEN_W'(1);
          state_d = ST_WR_GAP;
        end else if (tmo_expire) begin
          error_d = 1'b1;
          state_d = ST_FIN;
        end
      end

      ST_WR_GAP: begin
        if (rem_q == '0)  state_d = ST_FIN;
        else if (fill_q)  state_d = ST_WR_REQ;
        else              state_d = ST_RD_REQ;
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      rem_q   <= '0;
      data_q  <= 32'd0;
      fill_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Self-checking bench for mem_dma_copy with a zero-wait memory responder.
// Build with MEM_DMA_FILL_EN defined or not; the fill scenario adapts.
module tb_mem_dma_copy;
  import picobus_pkg::*;

  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             fill_mode = 1'b0;
  logic [31:0]      fill_data = '0;
  logic             busy, done, error;
  dma_state_t       dbg_state;

  mem_dma_copy_if bus ();

  always #5 clk = ~clk;

  mem_dma_copy #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_mode (fill_mode),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .mem_valid (bus.mem_valid),
    .mem_instr (bus.mem_instr),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_wstrb (bus.mem_wstrb),
    .mem_ready (bus.mem_ready),
    .mem_rdata (bus.mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- responder ----------------
  logic [31:0] mem_arr [0:255];
  logic        resp_en = 1'b1;
  logic        wr_stall = 1'b0;

  assign bus.mem_ready = bus.mem_valid && resp_en &&
                         !(wr_stall && (bus.mem_wstrb != WSTRB_NONE));
  assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  int          rd_cnt = 0, wr_cnt = 0, valid_cycles = 0, done_cnt = 0;

  // Observe the bus mid-cycle; each accepted write is checked against exp_q.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.mem_valid) valid_cycles++;
      if (done) done_cnt++;
      if (bus.mem_valid && bus.mem_ready) begin
        if (bus.mem_wstrb == WSTRB_NONE) begin
          rd_cnt++;
        end else begin
          wr_cnt++;
          mem_arr[bus.mem_addr[9:2]] = bus.mem_wdata;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL write_unexpected: got addr=%h data=%h, expected no write",
                     bus.mem_addr, bus.mem_wdata);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({bus.mem_addr, bus.mem_wdata} !== e) begin
              n_fail++;
              $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                       bus.mem_addr, bus.mem_wdata, e[63:32], e[31:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; valid_cycles = 0; done_cnt = 0;
  endtask

  // Leaves the caller one cycle after the edge that sampled start.
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int l,
                          input logic f, input logic [31:0] fd);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = LEN_W'(l); fill_mode = f; fill_data = fd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after start sampled) of done.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.mem_valid); end
    n_tests++; if (bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.mem_addr); end
    n_tests++; if (bus.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", bus.mem_wdata); end
    n_tests++; if (bus.mem_wstrb !== 4'b0000) begin n_fail++; $display("FAIL rst_wstrb: got %b expected 0000", bus.mem_wstrb); end
    n_tests++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got busy/done/error=%b expected 000", {busy, done, error}); end
    n_tests++; if (bus.mem_instr !== 1'b0) begin n_fail++; $display("FAIL rst_instr: got %b expected 0", bus.mem_instr); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected IDLE", dbg_state); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_copy();
    int cyc;
    mem_arr[64] = 32'hAAAA_0001; mem_arr[65] = 32'hBBBB_0002; mem_arr[66] = 32'hCCCC_0003;
    exp_q.push_back({32'h0000_0200, 32'hAAAA_0001});
    exp_q.push_back({32'h0000_0204, 32'hBBBB_0002});
    exp_q.push_back({32'h0000_0208, 32'hCCCC_0003});
    clear_counts();
    do_start(32'h100, 32'h200, 3, 1'b0, 32'h0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL copy_busy: got %b expected 1", busy); end
    wait_done(100, cyc);
    n_tests++; if (cyc !== 13) begin n_fail++; $display("FAIL copy_latency: got %0d expected 13", cyc); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL copy_error: got %b expected 0", error); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL copy_done_pulses: got %0d expected 1", done_cnt); end
    n_tests++; if (rd_cnt !== 3 || wr_cnt !== 3) begin n_fail++; $display("FAIL copy_counts: got rd=%0d wr=%0d expected 3/3", rd_cnt, wr_cnt); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL copy_pending: got %0d expected 0", exp_q.size()); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL copy_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_len0();
    int cyc;
    clear_counts();
    do_start(32'h100, 32'h200, 0, 1'b0, 32'h0);
    // done is seen in the cycle after start is sampled (second edge after start).
    wait_done(10, cyc);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL len0_latency: got %0d expected 1", cyc); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (valid_cycles !== 0) begin n_fail++; $display("FAIL len0_valid: got %0d expected 0", valid_cycles); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL len0_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_timeout();
    int cyc;
    clear_counts();
    resp_en = 1'b0;
    do_start(32'h100, 32'h200, 1, 1'b0, 32'h0);
    wait_done(100, cyc);
    n_tests++; if (cyc !== TIMEOUT + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", cyc, TIMEOUT + 1); end
    n_tests++; if (valid_cycles !== TIMEOUT) begin n_fail++; $display("FAIL tmo_valid_cycles: got %0d expected %0d", valid_cycles, TIMEOUT); end
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %b expected 1", error); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (error !== 1'b1 || bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_sticky: got error=%b valid=%b expected 1/0", error, bus.mem_valid); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL tmo_done_pulses: got %0d expected 1", done_cnt); end
    resp_en = 1'b1;
    exp_q.push_back({32'h0000_0300, mem_arr[64]});
    clear_counts();
    do_start(32'h100, 32'h300, 1, 1'b0, 32'h0);
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL tmo_error_clear: got %b expected 0", error); end
    wait_done(50, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL tmo_recover_latency: got %0d expected 5", cyc); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL tmo_recover_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int cyc;
    exp_q.push_back({32'hFFFF_FFFC, mem_arr[64]});
    exp_q.push_back({32'h0000_0000, mem_arr[65]});
    clear_counts();
    do_start(32'h100, 32'hFFFF_FFFC, 2, 1'b0, 32'h0);
    wait_done(50, cyc);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (wr_cnt !== 2 || exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap: got wr=%0d pending=%0d expected 2/0", wr_cnt, exp_q.size()); end
  endtask

  task automatic test_unaligned();
    int cyc;
    exp_q.push_back({32'h0000_0208, mem_arr[64]});
    clear_counts();
    do_start(32'h103, 32'h20A, 1, 1'b0, 32'h0);
    wait_done(50, cyc);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rd_cnt !== 1 || exp_q.size() !== 0) begin n_fail++; $display("FAIL unaligned: got rd=%0d pending=%0d expected 1/0", rd_cnt, exp_q.size()); end
  endtask

  task automatic test_fill();
    int cyc;
    for (int i = 0; i < 4; i++) mem_arr[80 + i] = $urandom;
`ifdef MEM_DMA_FILL_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h180 + 32'(4 * i), 32'hDEAD_BEEF});
`else
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h180 + 32'(4 * i), mem_arr[80 + i]});
`endif
    clear_counts();
    do_start(32'h140, 32'h180, 4, 1'b1, 32'hDEAD_BEEF);
    wait_done(100, cyc);
    repeat (2) @(posedge clk);
    #1;
`ifdef MEM_DMA_FILL_EN
    n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL fill_latency: got %0d expected 9", cyc); end
    n_tests++; if (rd_cnt !== 0 || wr_cnt !== 4) begin n_fail++; $display("FAIL fill_counts: got rd=%0d wr=%0d expected 0/4", rd_cnt, wr_cnt); end
`else
    n_tests++; if (cyc !== 17) begin n_fail++; $display("FAIL fill_latency: got %0d expected 17", cyc); end
    n_tests++; if (rd_cnt !== 4 || wr_cnt !== 4) begin n_fail++; $display("FAIL fill_counts: got rd=%0d wr=%0d expected 4/4", rd_cnt, wr_cnt); end
`endif
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL fill_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      int cyc, l, si, di;
      l  = $urandom_range(1, 6);
      si = $urandom_range(0, 31);
      di = $urandom_range(128, 180);
      for (int i = 0; i < l; i++) begin
        mem_arr[si + i] = $urandom;
        exp_q.push_back({32'(4 * (di + i)), mem_arr[si + i]});
      end
      clear_counts();
      do_start(32'(4 * si), 32'(4 * di), l, 1'b0, 32'h0);
      wait_done(100, cyc);
      n_tests++; if (cyc !== 4 * l + 1) begin n_fail++; $display("FAIL rand_latency: got %0d expected %0d", cyc, 4 * l + 1); end
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_pending: got %0d expected 0", exp_q.size()); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_q.push_back({32'h0000_0240, mem_arr[64]});
    exp_q.push_back({32'h0000_0244, mem_arr[65]});
    clear_counts();
    do_start(32'h100, 32'h240, 2, 1'b0, 32'h0);
    // A second request while busy must not disturb the running transfer.
    src_addr = 32'h0; dst_addr = 32'h380; len = LEN_W'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50, cyc);
    n_tests++; if (cyc !== 8) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 8", cyc); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (wr_cnt !== 2 || exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_ignore: got wr=%0d pending=%0d expected 2/0", wr_cnt, exp_q.size()); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc, guard;
    exp_q.push_back({32'h0000_0260, mem_arr[64]});
    clear_counts();
    do_start(32'h100, 32'h260, 3, 1'b0, 32'h0);
    guard = 0;
    while (wr_cnt < 1 && guard < 50) begin @(posedge clk); #1; guard++; end
    wr_stall = 1'b1;
    while (dbg_state !== ST_WR_REQ && guard < 50) begin @(posedge clk); #1; guard++; end
    n_tests++; if (bus.mem_valid !== 1'b1 || rd_cnt !== 2) begin n_fail++; $display("FAIL rmid_reach: got valid=%b rd=%0d expected 1/2", bus.mem_valid, rd_cnt); end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (bus.mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got valid/busy/done=%b expected 000", {bus.mem_valid, busy, done}); end
    @(posedge clk); #1;
    resetn = 1'b1;
    wr_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (done_cnt !== 0 || wr_cnt !== 1 || exp_q.size() !== 0) begin n_fail++; $display("FAIL rmid_nodone: got done=%0d wr=%0d pending=%0d expected 0/1/0", done_cnt, wr_cnt, exp_q.size()); end
    exp_q.push_back({32'h0000_0270, mem_arr[65]});
    clear_counts();
    do_start(32'h104, 32'h270, 1, 1'b0, 32'h0);
    wait_done(50, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL rmid_recover: got %0d expected 5", cyc); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rmid_pending: got %0d expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    test_reset();
    test_copy();
    test_len0();
    test_timeout();
    test_wrap();
    test_unaligned();
    test_fill();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
